fir_mac_sequencer: RTL
======================

// Module: fir_mac_sequencer
// PURPOSE
//  Synchronous sequencer for the time-multiplexed FIR MAC datapath. Accepts one input sample
//  per srdyi strobe and writes it into the circular sample buffer. Then steps the coefficient
//  select and sample read address across all taps, driving accumulator clear/enable.
//  Pulses srdyo when the filtered output is valid. Sits between the sample source and the
//  coeff ROM / sample RAM / accumulator.
// PARAMETERS
//  NTAPS        12  number of filter taps (coeff_sel range 0..NTAPS-1)
//  SEL_W         4  width of coeff_sel and buffer addresses; 2**SEL_W >= NTAPS
//  PIPE          1  datapath latency, MAC issue to accumulator settled (cycles, >=0)
//  MAX_SAMPLES  20  samples per run before done; 0 = unlimited
//  CNT_W         5  width of sample_count
// PORTS
//  clk           in   1      clock, all state on rising edge
//  GlobalReset   in   1      reset, asynchronous, active-high
//  global_srdyi  in   1      run arm pulse: clears sample_count/done/overrun, enables acceptance
//  srdyi         in   1      input sample strobe (1-cycle pulse)
//  ready         out  1      1 = srdyi will be accepted this cycle
//  wr_en         out  1      sample buffer write strobe
//  wr_addr       out  SEL_W  sample buffer write address (= wr_ptr)
//  rd_addr       out  SEL_W  sample buffer read address for current tap
//  coeff_sel     out  SEL_W  coefficient ROM select for current tap
//  sum_rst       out  1      accumulator synchronous clear
//  sum_en        out  1      accumulator accumulate enable
//  srdyo         out  1      output sample valid (1-cycle pulse)
//  sample_count  out  CNT_W  outputs produced since last arm
//  done          out  1      MAX_SAMPLES reached; held until next arm
//  overrun       out  1      sticky: srdyi arrived while not ready
// BEHAVIOUR
//  Reset: state=IDLE, armed=0, wr_ptr=0, all outputs 0 (ready=0 until armed).
//  FSM: IDLE -> CLEAR -> MAC -> DRAIN -> OUT -> IDLE.
//   IDLE: ready=armed&~done. srdyi&ready: wr_en=1, wr_addr=wr_ptr; go CLEAR.
//   CLEAR (1 cyc): sum_rst=1, tap k=0.
//   MAC (NTAPS cyc): sum_en=1, coeff_sel=k, rd_addr=(wr_ptr-k) mod NTAPS; k++.
//   After last tap: wr_ptr=(wr_ptr+1) mod NTAPS (NTAPS-1 wraps to 0); go DRAIN.
//   DRAIN (PIPE cyc; skipped if PIPE=0): all strobes 0.
//   OUT (1 cyc): srdyo=1, sample_count++. If MAX_SAMPLES!=0 and new count==MAX_SAMPLES: done=1, armed=0.
//  Latency: srdyi accepted in cycle 0 -> srdyo in cycle NTAPS+2+PIPE (15 at defaults).
//  Throughput: one sample per NTAPS+3+PIPE cycles max.
//  srdyi while ready=0 (busy, unarmed, or done): sample dropped, overrun=1 (sticky until arm/reset).
//  global_srdyi: armed=1; count/done/overrun cleared. Does not disturb a sample in flight.
//  Same-cycle global_srdyi and srdyi in IDLE: arm applies first, sample accepted.
//  sample_count saturates at 2**CNT_W-1 when MAX_SAMPLES=0.
//  coeff_sel, rd_addr hold 0 outside MAC. wr_en, sum_rst, sum_en, srdyo never overlap.
//  Reset mid-operation: immediate return to reset state, no srdyo, buffer contents don't care.
// STRUCTURE
//  fir_ctrl_defs.vh (shared include): state encodings, NTAPS/SEL_W defaults for ROM/RAM/accumulator.
//  Sub-module fir_circ_ptr: mod-NTAPS pointer, increment and (base-k) subtract, no power-of-2 need.
//  Remaining FSM, tap counter, sample counter and flags live in this top.
// TESTING
//  Reset, arm, one srdyi:
//   wr_en@0 addr0; sum_rst@1; sum_en@2..13 with coeff_sel 0..11, rd_addr 0,11,10..1; srdyo@15.
//  13 back-to-back samples at max rate:
//   wr_addr 0..11 then wraps to 0; 13th sample's rd_addr starts at 0, then 11.
//  srdyi at cycle 5 of processing:
//   dropped, overrun=1, srdyo count unchanged; next arm clears overrun.
//  20 samples, MAX_SAMPLES=20:
//   done=1 after 20th srdyo; 21st srdyi ignored with overrun=1.
//   global_srdyi -> count=0, done=0, accepts again.
//  GlobalReset asserted during MAC:
//   all outputs 0 asynchronously; no srdyo; after re-arm the next sample writes wr_addr 0.
//  global_srdyi and srdyi in same cycle while done=1:
//   sample accepted, sample_count counts 1 at its srdyo.

Source files
------------

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared parameters and FSM state encoding for the FIR MAC sequencer and the
// coeff ROM / sample RAM / accumulator it drives.
package fir_mac_sequencer_pkg;

    localparam int DEF_NTAPS       = 12;
    localparam int DEF_SEL_W       = 4;
    localparam int DEF_PIPE        = 1;
    localparam int DEF_MAX_SAMPLES = 20;
    localparam int DEF_CNT_W       = 5;
    localparam int DRN_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/fir_circ_ptr.sv
// Combinational mod-NTAPS pointer arithmetic: base+1 and base-k, zero latency.
// NTAPS need not be a power of two; k is assumed to lie in 0..NTAPS-1.
module fir_circ_ptr #(
    parameter int NTAPS = 12,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] base,
    input  logic [SEL_W-1:0] k,
    output logic [SEL_W-1:0] inc,
    output logic [SEL_W-1:0] diff
);

    always_comb begin
        inc  = (base == SEL_W'(NTAPS - 1)) ? '0 : base + SEL_W'(1);
        // Wrapped result is below NTAPS, so modulo-2**SEL_W arithmetic is exact.
        diff = (base >= k) ? base - k : base + SEL_W'(NTAPS) - k;
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for the time-multiplexed FIR MAC: srdyi accepted in cycle 0, srdyo in cycle NTAPS+2+PIPE.
// No backpressure: srdyi while ready=0 is dropped and flagged in sticky overrun.
module fir_mac_sequencer
    import fir_mac_sequencer_pkg::*;
#(
    parameter int NTAPS       = DEF_NTAPS,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int PIPE        = DEF_PIPE,
    parameter int MAX_SAMPLES = DEF_MAX_SAMPLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             global_srdyi,
    input  logic             srdyi,
    output logic             ready,
    output logic             wr_en,
    output logic [SEL_W-1:0] wr_addr,
    output logic [SEL_W-1:0] rd_addr,
    output logic [SEL_W-1:0] coeff_sel,
    output logic             sum_rst,
    output logic             sum_en,
    output logic             srdyo,
    output logic [CNT_W-1:0] sample_count,
    output logic             done,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [SEL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SEL_W-1:0] tap_q, tap_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEL_W-1:0] ptr_inc, ptr_diff;

    fir_circ_ptr #(
        .NTAPS (NTAPS),
        .SEL_W (SEL_W)
    ) u_circ_ptr (
        .base (wr_ptr_q),
        .k    (tap_q),
        .inc  (ptr_inc),
        .diff (ptr_diff)
    );

    always_comb begin
        state_d   = state_q;
        // An arm takes effect before anything else this cycle, including acceptance.
        armed_d   = armed_q | global_srdyi;
        done_d    = done_q & ~global_srdyi;
        overrun_d = overrun_q & ~global_srdyi;
        count_d   = global_srdyi ? '0 : count_q;
        wr_ptr_d  = wr_ptr_q;
        tap_d     = tap_q;
        drain_d   = drain_q;
        ready     = (state_q == ST_IDLE) && armed_d && !done_d;
        wr_en     = 1'b0;
        sum_rst   = 1'b0;
        sum_en    = 1'b0;
        srdyo     = 1'b0;
        coeff_sel = '0;
        rd_addr   = '0;

        if (srdyi && !ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (srdyi && ready) begin
                    wr_en   = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                sum_rst = 1'b1;
                tap_d   = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                sum_en    = 1'b1;
                coeff_sel = tap_q;
                rd_addr   = ptr_diff;
                if (tap_q == SEL_W'(NTAPS - 1)) begin
                    tap_d    = '0;
                    wr_ptr_d = ptr_inc;
                    drain_d  = '0;
                    state_d  = (PIPE == 0) ? ST_OUT : ST_DRAIN;
                end else begin
                    tap_d = tap_q + SEL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(PIPE - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            ST_OUT: begin
                srdyo   = 1'b1;
                state_d = ST_IDLE;
                if (count_d != '1) begin
                    count_d = count_d + CNT_W'(1);
                end
                if (MAX_SAMPLES != 0 && count_d == CNT_W'(MAX_SAMPLES)) begin
                    done_d  = 1'b1;
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr_ptr_q  <= '0;
            tap_q     <= '0;
            drain_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            wr_ptr_q  <= wr_ptr_d;
            tap_q     <= tap_d;
            drain_q   <= drain_d;
            count_q   <= count_d;
        end
    end

    assign wr_addr      = wr_ptr_q;
    assign sample_count = count_q;
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule
